// File: rtl/pio_irq_service_master_if.sv
// rtl/pio_irq_service_master_if.sv - Avalon-MM initiator and event stream bundle for the PIO irq service master
interface pio_irq_service_master_if #(
   parameter int unsigned W = 2
);
   logic [1:0]   avm_address;
   logic         avm_chipselect;
   logic         avm_write_n;
   logic [31:0]  avm_writedata;
   logic [31:0]  avm_readdata;
   logic         avm_waitrequest;
   logic         evt_valid;
   logic         evt_ready;
   logic [W-1:0] evt_keys;
   logic [W-1:0] evt_levels;

   modport master (
      output avm_address, avm_chipselect, avm_write_n, avm_writedata,
      input  avm_readdata, avm_waitrequest,
      output evt_valid, evt_keys, evt_levels,
      input  evt_ready
   );

   modport slave (
      input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
      output avm_readdata, avm_waitrequest,
      input  evt_valid, evt_keys, evt_levels,
      output evt_ready
   );
endinterface

// File: rtl/pio_irq_service_master.sv
// rtl/pio_irq_service_master.sv - services an edge-capture PIO on irq and emits one event word per service
// Optional level snapshot (RD_LVL state) enabled by PIO_IRQ_SERVICE_LEVEL_READ_EN.
module pio_irq_service_master #(
   parameter int unsigned  W            = 2,
   parameter logic [W-1:0] MASK_INIT    = '1,
   parameter int unsigned  READ_LATENCY = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic irq_in,
   output logic busy,
   pio_irq_service_master_if.master bus
);
   localparam logic [1:0]  OFS_DATA  = 2'd0;
   localparam logic [1:0]  OFS_MASK  = 2'd2;
   localparam logic [1:0]  OFS_CAP   = 2'd3;
   localparam logic [31:0] MASK_WORD = 32'(MASK_INIT);
   localparam logic [2:0]  RD_LAST   = 3'(READ_LATENCY);

`ifdef PIO_IRQ_SERVICE_LEVEL_READ_EN
   typedef enum logic [2:0] {
      S_INIT_MASK, S_INIT_CLR, S_IDLE, S_RD_CAP, S_CLR_CAP, S_RD_LVL, S_EMIT
   } state_t;
`else
   typedef enum logic [2:0] {
      S_INIT_MASK, S_INIT_CLR, S_IDLE, S_RD_CAP, S_CLR_CAP, S_EMIT
   } state_t;
`endif

   state_t       state_q;
   logic         cs_q;
   logic         write_n_q;
   logic [1:0]   addr_q;
   logic [31:0]  wdata_q;
   logic [2:0]   lat_q;
   logic         evt_valid_q;
   logic [W-1:0] keys_q;
   logic         suppress_q;
   logic         busy_q;
`ifdef PIO_IRQ_SERVICE_LEVEL_READ_EN
   logic [W-1:0] levels_q;
`endif

   logic         cmd_en;
   logic         cmd_write;
   logic [1:0]   cmd_addr;
   logic [31:0]  cmd_data;
   logic         wr_done;
   logic         rd_done;
   logic [W-1:0] rd_bits;
   logic         unused_rdata;

   assign rd_bits      = bus.avm_readdata[W-1:0];
   assign unused_rdata = ^bus.avm_readdata[31:W];
   assign wr_done      = cs_q && !write_n_q && !bus.avm_waitrequest;
   assign rd_done      = cs_q && write_n_q && (lat_q == RD_LAST);

   // Command each bus state issues once chipselect has been low for a cycle.
   always_comb begin
      cmd_en    = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = OFS_DATA;
      cmd_data  = 32'd0;
      case (state_q)
         S_INIT_MASK: begin
            cmd_en    = 1'b1;
            cmd_write = 1'b1;
            cmd_addr  = OFS_MASK;
            cmd_data  = MASK_WORD;
         end
         S_INIT_CLR, S_CLR_CAP: begin
            cmd_en    = 1'b1;
            cmd_write = 1'b1;
            cmd_addr  = OFS_CAP;
            cmd_data  = '1;
         end
         S_RD_CAP: begin
            cmd_en   = 1'b1;
            cmd_addr = OFS_CAP;
         end
`ifdef PIO_IRQ_SERVICE_LEVEL_READ_EN
         S_RD_LVL: begin
            cmd_en   = 1'b1;
            cmd_addr = OFS_DATA;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_INIT_MASK;
         cs_q        <= 1'b0;
         write_n_q   <= 1'b1;
         addr_q      <= 2'd0;
         wdata_q     <= 32'd0;
         lat_q       <= 3'd0;
         evt_valid_q <= 1'b0;
         keys_q      <= '0;
         suppress_q  <= 1'b0;
         busy_q      <= 1'b1;
`ifdef PIO_IRQ_SERVICE_LEVEL_READ_EN
         levels_q    <= '0;
`endif
      end else begin
         // Bus phase: writes end on acceptance; reads count latency once accepted.
         if (cs_q) begin
            if (!write_n_q) begin
               if (!bus.avm_waitrequest) begin
                  cs_q      <= 1'b0;
                  write_n_q <= 1'b1;
               end
            end else if (rd_done) begin
               cs_q <= 1'b0;
            end else if (lat_q != 3'd0 || !bus.avm_waitrequest) begin
               lat_q <= lat_q + 3'd1;
            end
         end else if (cmd_en) begin
            cs_q      <= 1'b1;
            write_n_q <= !cmd_write;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_data;
            lat_q     <= 3'd0;
         end

         case (state_q)
            S_INIT_MASK: begin
               if (wr_done) state_q <= S_INIT_CLR;
            end
            S_INIT_CLR: begin
               if (wr_done) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            S_IDLE: begin
               if (irq_in) begin
                  state_q <= S_RD_CAP;
                  busy_q  <= 1'b1;
               end
            end
            S_RD_CAP: begin
               if (rd_done) begin
                  keys_q     <= rd_bits;
                  suppress_q <= (rd_bits == '0);
                  state_q    <= S_CLR_CAP;
               end
            end
            S_CLR_CAP: begin
               if (wr_done) begin
                  if (suppress_q) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
`ifdef PIO_IRQ_SERVICE_LEVEL_READ_EN
                     state_q <= S_RD_LVL;
`else
                     state_q     <= S_EMIT;
                     evt_valid_q <= 1'b1;
`endif
                  end
               end
            end
`ifdef PIO_IRQ_SERVICE_LEVEL_READ_EN
            S_RD_LVL: begin
               if (rd_done) begin
                  levels_q    <= rd_bits;
                  state_q     <= S_EMIT;
                  evt_valid_q <= 1'b1;
               end
            end
`endif
            S_EMIT: begin
               if (bus.evt_ready) begin
                  evt_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
                  busy_q      <= 1'b0;
               end
            end
            default: state_q <= S_INIT_MASK;
         endcase
      end
   end

   assign bus.avm_address    = addr_q;
   assign bus.avm_chipselect = cs_q;
   assign bus.avm_write_n    = write_n_q;
   assign bus.avm_writedata  = wdata_q;
   assign bus.evt_valid      = evt_valid_q;
   assign bus.evt_keys       = keys_q;
`ifdef PIO_IRQ_SERVICE_LEVEL_READ_EN
   assign bus.evt_levels     = levels_q;
`else
   assign bus.evt_levels     = '0;
`endif
   assign busy               = busy_q;
endmodule

// File: tb/tb_pio_irq_service_master.sv
// tb/tb_pio_irq_service_master.sv - directed and randomized bench with a 2-bit key PIO responder model
module tb_pio_irq_service_master;
   localparam int W = 2;
`ifdef PIO_IRQ_SERVICE_LEVEL_READ_EN
   localparam bit LVL = 1'b1;
`else
   localparam bit LVL = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   logic irq_in;
   logic busy;
   always #5 clk = ~clk;

   pio_irq_service_master_if #(.W(W)) bus_if ();

   pio_irq_service_master #(.W(W), .MASK_INIT(2'b11), .READ_LATENCY(1)) dut (
      .clk(clk), .reset_n(reset_n), .irq_in(irq_in), .busy(busy), .bus(bus_if)
   );

   // Key PIO responder: falling-edge capture, any write to offset 3 clears it.
   logic        pio_rstn;
   logic [1:0]  keys, key_prev, pio_mask, ecap;
   logic        irq_force;
   int          wr_count;
   logic [1:0]  wr_addr_log [0:255];
   logic [31:0] wr_data_log [0:255];
   logic        acc;

   assign acc    = bus_if.avm_chipselect && !bus_if.avm_waitrequest;
   assign irq_in = (|(ecap & pio_mask)) | irq_force;

   always @(posedge clk) begin
      if (!pio_rstn) begin
         key_prev <= 2'b11;
         pio_mask <= 2'b00;
         ecap <= 2'b00;
         bus_if.avm_readdata <= 32'd0;
         wr_count <= 0;
      end else begin
         key_prev <= keys;
         ecap <= ((acc && !bus_if.avm_write_n && bus_if.avm_address == 2'd3) ? 2'b00 : ecap)
                 | (key_prev & ~keys);
         if (acc && !bus_if.avm_write_n) begin
            wr_addr_log[wr_count % 256] <= bus_if.avm_address;
            wr_data_log[wr_count % 256] <= bus_if.avm_writedata;
            wr_count <= wr_count + 1;
            if (bus_if.avm_address == 2'd2) pio_mask <= bus_if.avm_writedata[1:0];
         end else if (acc) begin
            case (bus_if.avm_address)
               2'd0: bus_if.avm_readdata <= {30'd0, keys};
               2'd2: bus_if.avm_readdata <= {30'd0, pio_mask};
               2'd3: bus_if.avm_readdata <= {30'd0, ecap};
               default: bus_if.avm_readdata <= 32'd0;
            endcase
         end
      end
   end

   int checks;
   int failures;
   bit rand_wait;
   logic [1:0] pending;
   logic [1:0] f;
   logic [1:0] a0;
   logic [31:0] d0;
   int lat, n, base, hold;
   bit flag_a, flag_b, flag_c;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (rand_wait) bus_if.avm_waitrequest = ($urandom_range(0, 3) == 0);
   endtask

   task automatic wait_valid(input int limit, output int cyc);
      cyc = 0;
      while (bus_if.evt_valid !== 1'b1 && cyc < limit) begin
         tick();
         cyc++;
      end
      check("evt_valid_wait", {31'd0, bus_if.evt_valid}, 32'd1);
   endtask

   task automatic wait_idle(input int limit);
      int cyc;
      cyc = 0;
      while (busy !== 1'b0 && cyc < limit) begin
         tick();
         cyc++;
      end
      check("idle_wait", {31'd0, busy}, 32'd0);
   endtask

   task automatic check_event(input logic [1:0] exp_keys);
      check("evt_keys", {30'd0, bus_if.evt_keys}, {30'd0, exp_keys});
      check("evt_levels", {30'd0, bus_if.evt_levels}, {30'd0, (LVL ? keys : 2'b00)});
   endtask

   task automatic accept();
      bus_if.evt_ready = 1'b1;
      tick();
      bus_if.evt_ready = 1'b0;
      check("accept_valid_low", {31'd0, bus_if.evt_valid}, 32'd0);
   endtask

   task automatic check_init(input int first);
      check("init_wr_count", wr_count - first, 2);
      check("init_wr0_addr", {30'd0, wr_addr_log[first % 256]}, 32'd2);
      check("init_wr0_data", wr_data_log[first % 256], 32'h3);
      check("init_wr1_addr", {30'd0, wr_addr_log[(first + 1) % 256]}, 32'd3);
      check("init_wr1_data", wr_data_log[(first + 1) % 256], 32'hFFFF_FFFF);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; failures = 0; rand_wait = 1'b0; pending = 2'b00;
      keys = 2'b11; irq_force = 1'b0;
      bus_if.avm_waitrequest = 1'b0; bus_if.evt_ready = 1'b0;
      pio_rstn = 1'b0; reset_n = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_cs", {31'd0, bus_if.avm_chipselect}, 32'd0);
      check("rst_write_n", {31'd0, bus_if.avm_write_n}, 32'd1);
      check("rst_addr", {30'd0, bus_if.avm_address}, 32'd0);
      check("rst_wdata", bus_if.avm_writedata, 32'd0);
      check("rst_valid", {31'd0, bus_if.evt_valid}, 32'd0);
      check("rst_keys", {30'd0, bus_if.evt_keys}, 32'd0);
      check("rst_levels", {30'd0, bus_if.evt_levels}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd1);

      pio_rstn = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      wait_idle(50);
      check_init(0);

      // key[1] falls: measured irq-to-valid latency with no stalls
      base = wr_count;
      keys = 2'b01; pending = 2'b10;
      tick();
      check("irq_asserted", {31'd0, irq_in}, 32'd1);
      wait_valid(50, lat);
      check("latency", lat, LVL ? 9 : 6);
      check_event(pending);
      check("irq_cleared", {31'd0, irq_in}, 32'd0);
      check("svc_wr_count", wr_count - base, 1);
      check("svc_wr_addr", {30'd0, wr_addr_log[(wr_count - 1) % 256]}, 32'd3);
      pending = 2'b00;
      accept();

      // Back-pressure: held event stays stable, bus quiet, merged follow-up
      keys = 2'b11; tick(); tick();
      keys = 2'b01; pending = 2'b10;
      wait_valid(50, lat);
      check_event(pending);
      keys = 2'b00; pending = 2'b01;
      flag_a = 1'b0; flag_b = 1'b0; flag_c = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus_if.avm_chipselect !== 1'b0) flag_a = 1'b1;
         if (bus_if.evt_valid !== 1'b1) flag_b = 1'b1;
         if (bus_if.evt_keys !== 2'b10) flag_c = 1'b1;
      end
      check("bp_bus_quiet", {31'd0, flag_a}, 32'd0);
      check("bp_valid_held", {31'd0, flag_b}, 32'd0);
      check("bp_keys_held", {31'd0, flag_c}, 32'd0);
      accept();
      wait_valid(50, lat);
      check_event(pending);
      pending = 2'b00;
      accept();

      // Waitrequest stall on the clear write
      keys = 2'b11; tick(); tick();
      base = wr_count;
      keys = 2'b10; pending = 2'b01;
      n = 0;
      while (!(bus_if.avm_chipselect === 1'b1 && bus_if.avm_write_n === 1'b0) && n < 50) begin
         tick();
         n++;
      end
      check("ws_write_seen", {31'd0, bus_if.avm_chipselect && !bus_if.avm_write_n}, 32'd1);
      a0 = bus_if.avm_address; d0 = bus_if.avm_writedata;
      bus_if.avm_waitrequest = 1'b1;
      flag_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus_if.avm_chipselect !== 1'b1 || bus_if.avm_write_n !== 1'b0 ||
             bus_if.avm_address !== a0 || bus_if.avm_writedata !== d0) flag_a = 1'b1;
      end
      bus_if.avm_waitrequest = 1'b0;
      check("ws_stable", {31'd0, flag_a}, 32'd0);
      check("ws_addr", {30'd0, a0}, 32'd3);
      wait_valid(50, lat);
      check_event(pending);
      check("ws_wr_count", wr_count - base, 1);
      pending = 2'b00;
      accept();

      // Spurious irq with empty capture register
      base = wr_count;
      irq_force = 1'b1;
      tick();
      irq_force = 1'b0;
      flag_a = 1'b0; flag_b = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus_if.evt_valid === 1'b1) flag_a = 1'b1;
         if (bus_if.avm_chipselect === 1'b1 && bus_if.avm_write_n === 1'b1 &&
             bus_if.avm_address === 2'd3) flag_b = 1'b1;
      end
      check("spur_no_event", {31'd0, flag_a}, 32'd0);
      check("spur_read_seen", {31'd0, flag_b}, 32'd1);
      check("spur_wr_count", wr_count - base, 1);
      check("spur_wr_addr", {30'd0, wr_addr_log[(wr_count - 1) % 256]}, 32'd3);
      check("spur_idle", {31'd0, busy}, 32'd0);

      // Reset asserted during the capture read
      keys = 2'b00;
      n = 0;
      while (!(bus_if.avm_chipselect === 1'b1 && bus_if.avm_write_n === 1'b1) && n < 50) begin
         tick();
         n++;
      end
      check("mid_read_seen", {31'd0, bus_if.avm_chipselect}, 32'd1);
      #1 reset_n = 1'b0;
      #1;
      check("mid_rst_cs", {31'd0, bus_if.avm_chipselect}, 32'd0);
      check("mid_rst_valid", {31'd0, bus_if.evt_valid}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      base = wr_count;
      reset_n = 1'b1;
      wait_idle(50);
      check_init(base);
      check("reinit_irq_low", {31'd0, irq_in}, 32'd0);
      pending = 2'b00;

      // key[0] falls while key[1] is held low
      keys = 2'b01; tick(); tick();
      keys = 2'b00; pending = 2'b01;
      wait_valid(50, lat);
      check_event(pending);
      pending = 2'b00;
      accept();

      // Randomized edges, stalls and back-pressure
      rand_wait = 1'b1;
      keys = 2'b11; tick(); tick();
      for (int it = 0; it < 25; it++) begin
         if (pending == 2'b00) begin
            if (keys == 2'b00) begin
               keys = 2'($urandom_range(1, 3));
               tick(); tick();
            end
            f = 2'b00;
            while (f == 2'b00) f = 2'($urandom_range(1, 3)) & keys;
            keys = keys & ~f;
            pending = f;
         end
         wait_valid(300, lat);
         check_event(pending);
         pending = 2'b00;
         hold = $urandom_range(0, 6);
         if ($urandom_range(0, 1) == 1 && keys != 2'b00) begin
            f = 2'b00;
            while (f == 2'b00) f = 2'($urandom_range(1, 3)) & keys;
            keys = keys & ~f;
            pending = f;
         end
         repeat (hold) tick();
         accept();
         if (pending == 2'b00) begin
            keys = keys | 2'($urandom_range(0, 3));
            tick(); tick();
         end
      end
      if (pending != 2'b00) begin
         wait_valid(300, lat);
         check_event(pending);
         accept();
      end
      rand_wait = 1'b0;
      bus_if.avm_waitrequest = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
